// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state enum and default sizes for the multi-port register file
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_state_e;

  localparam int RF_XLEN  = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NREAD = 2;

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - post-reset clear sequencer: walks entries 1..DEPTH-1 writing zero
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  output logic                     clr_we,
  output logic [$clog2(DEPTH)-1:0] clr_addr
);

  localparam int AW = $clog2(DEPTH);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry 0 is hardwired to zero on read, so the sweep starts at 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        busy = 1'b0;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = AW'(1);
      end
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - one-write, NREAD-read register file with x0 = 0 and self-clear after reset
// Optional same-edge write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int DEPTH = RF_DEPTH,
  parameter int NREAD = RF_NREAD,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wd_en,
  input  logic [AW-1:0]         wd_sel,
  input  logic [XLEN-1:0]       data,
  input  logic                  rd_en,
  input  logic [NREAD*AW-1:0]   rs_add,
  output logic [NREAD*XLEN-1:0] rs,
  output logic                  rd_valid,
  output logic                  busy
);

  logic            busy_w;
  logic            clr_we;
  logic [AW-1:0]   clr_addr;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] port_data [NREAD];

  logic [NREAD*XLEN-1:0] rs_q, rs_d;
  logic                  rd_valid_q, rd_valid_d;

  regfile_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy_w),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // The sequencer owns the write port until the sweep finishes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wd_sel;
    wr_data = data;
    if (busy_w) begin
      wr_en   = clr_we;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (wd_en && (wd_sel != '0)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rs_add[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    // addr != 0 already excludes the discarded x0 write from forwarding.
    assign hit          = wd_en && (addr == wd_sel);
    assign port_data[i] = (addr == '0) ? '0 : (hit ? data : mem_q[addr]);
`else
    assign port_data[i] = (addr == '0) ? '0 : mem_q[addr];
`endif
  end

  always_comb begin
    rs_d       = rs_q;
    rd_valid_d = 1'b0;
    if (rd_en && !busy_w) begin
      rd_valid_d = 1'b1;
      for (int i = 0; i < NREAD; i++) begin
        rs_d[i*XLEN +: XLEN] = port_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rs_q       <= rs_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rs       = rs_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_w;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RISC-V core: one write port, `NREAD` registered read ports, and entry 0 hardwired to zero. After reset, a built-in clear sequencer zeroes the array one entry per cycle; all accesses are stalled while it runs. It sits between decode (read addresses) and writeback (write port), and replaces the fixed 32×32, two-read-port register file.

## Interface
- `XLEN`, 32, data width in bits
- `DEPTH`, 32, number of entries; power of two, ≥ 4
- `NREAD`, 2, number of read ports, 1–4
- `AW`, `$clog2(DEPTH)`, address width; derived, never overridden
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wd_en`  in  1  write enable
- `wd_sel`  in  AW  write address
- `data`  in  XLEN  write data
- `rd_en`  in  1  read enable; samples all read ports together
- `rs_add`  in  NREAD*AW  packed read addresses; port i occupies bits [i*AW +: AW]
- `rs`  out  NREAD*XLEN  packed registered read data; port i occupies bits [i*XLEN +: XLEN]
- `rd_valid`  out  1  `rs` was updated by a read accepted on the previous edge
- `busy`  out  1  clear sequence in progress; accesses are ignored

## Operation
- States: `CLEAR` and `IDLE`. Reset forces `CLEAR`, with the clear counter set to 1.
- `CLEAR`: each edge writes 0 to entry `counter`, then increments it. The edge that clears entry DEPTH-1 moves the FSM to `IDLE`. `busy` = 1 throughout `CLEAR`.
- While `busy`: `wd_en` and `rd_en` are ignored, `rs` holds its value, and `rd_valid` = 0.
- Write (`IDLE`): if `wd_en` and `wd_sel` ≠ 0, then entry `wd_sel` ← `data` on the edge. Writes to address 0 are discarded silently.
- Read (`IDLE`): if `rd_en`, each port's `rs[i]` ← entry `rs_add[i]` on the edge, and `rd_valid` ← 1. Otherwise `rs` holds and `rd_valid` ← 0.
- Address 0 always reads 0, regardless of the array contents.
- Several ports may read the same address in one cycle, and each receives the same value.
- A write and a read to the same nonzero address on the same edge follow the bypass rule under Configuration.
- A write and a read to different addresses on the same edge do not interact.

## Timing
- Reset values: `rs` = 0, `rd_valid` = 0, `busy` = 1, state = `CLEAR`, counter = 1. Array contents are undefined until the clear completes.
- `busy` stays high for exactly DEPTH-1 rising edges after `rst` deasserts. The first access is accepted on edge DEPTH (counting from 1).
- Read latency: 1 cycle. Addresses are sampled on edge N, and data and `rd_valid` are visible after edge N.
- Write latency: 1 cycle. Data written on edge N is returned by a read sampled on edge N+1.
- If reset asserts mid-clear or mid-operation, all state returns to its reset values immediately, and the clear restarts from entry 1.
- No combinational path exists from any input to any output.

## Configuration
- `REGFILE_BYPASS_EN` defined: on the same edge, if `wd_en`, `rd_en`, `rs_add[i] == wd_sel`, and `wd_sel` ≠ 0, then port i captures `data` (the new value).
- `REGFILE_BYPASS_EN` undefined: in the same case, port i captures the old array contents. The consumer must then wait one cycle to see the new value.
- The address-0-reads-zero rule holds in both builds.

## Structure
- Package `regfile_pkg` holds:
  - the state enum `rf_state_e` {`CLEAR`, `IDLE`}
  - the default constants `RF_XLEN` = 32, `RF_DEPTH` = 32, `RF_NREAD` = 2
- Sub-module `regfile_clear_seq` holds the FSM, counter, and `busy` logic. It outputs the clear write enable and clear address, and is parametrised by `DEPTH`.
- The top level holds:
  - the array
  - a write mux that selects between the clear path and the user write
  - a generate loop that builds the read ports and per-port bypass compare

## Test plan
- Reset with the default parameters, then release: `busy` is high for 31 edges. Then read x5 and x31 via ports 0 and 1 → `rs` = 0, 0, and `rd_valid` = 1 one cycle later.
- Write 0xDEADBEEF to x7, then read x7 on the next edge → `rs[0]` = 0xDEADBEEF. Write 0x1234 to x0, then read x0 → 0.
- With x3 = 0x11, write 0x22 to x3 and read x3 on the same edge:
  - bypass build → 0x22
  - non-bypass build → 0x11
  - a repeat read on the next edge → 0x22 in both builds
- Assert `wd_en` = 1 and `rd_en` = 1 while `busy`: no array change, `rd_valid` stays 0, and `rs` holds 0.
- Write x9 = 0xA5A5A5A5, then assert `rst` mid-cycle (asynchronously) for 1 cycle: `rs` → 0 and `busy` → 1 immediately. After the clear, reading x9 → 0.
- With `NREAD` = 4, `DEPTH` = 16, `XLEN` = 64: `busy` lasts 15 edges. After writing x1..x4 = 1..4, a read with addresses {4, 3, 2, 1} → `rs` = {4, 3, 2, 1}.
